pipe_int_mul_arbiter: RTL and testbench

- Shares one pipelined integer multiplier among NREQ requesters, each with a val/rdy request port and a val/rdy response port.
- Round-robin arbiter picks one request per cycle and forwards operands on the multiplier's val_op/oprand_rdy interface.
- Requester tags are kept in an in-order tag FIFO; each single-cycle multiplier commit pulse is matched to the oldest tag and queued in a response FIFO for return to the right requester.
- Sits between the client units and the multiplier core; the multiplier itself is unchanged.

---
 rtl/pipe_int_mul_arbiter.sv | 153 +++++++++++++++
 tb/tb_pipe_int_mul_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_int_mul_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; PIPE_INT_MUL_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: request->multiplier 0 cycles, commit->resp_val 1 cycle; credit stalls issue, head-of-line blocks responses.
module pipe_int_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   resp_val,
    input  logic [NREQ-1:0]   resp_rdy,
    output logic [W-1:0]      resp_result,
    output logic              mul_val_op,
    input  logic              mul_oprand_rdy,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_commit,
    input  logic [W-1:0]      mul_result
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TW-1:0] grant;
    logic          grant_vld;
    logic          may_issue;
    logic          fire;
    logic          commit_ok;
    logic          rsp_empty;
    logic          rsp_pop;
    logic [TW-1:0] head_tag;

    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [AW-1:0] tag_wr_q, tag_rd_q;
    logic [AW-1:0] rsp_wr_q, rsp_rd_q;
    logic [W-1:0]  mul_a_q, mul_b_q;
    logic          err_orphan_q;

    logic [TW-1:0] tag_mem     [DEPTH];
    logic [TW-1:0] rsp_tag_mem [DEPTH];
    logic [W-1:0]  rsp_dat_mem [DEPTH];

    // Responses already buffered still hold credit, so a stalled consumer throttles issue.
    assign may_issue = ({1'b0, infl_q} + {1'b0, rsp_cnt_q}) < (CW+1)'(DEPTH);

`ifdef PIPE_INT_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_val[k]) begin
                grant_vld = 1'b1;
                grant     = TW'(k);
            end
        end
    end
`else
    logic [TW-1:0] rr_q, rr_d;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!grant_vld && req_val[idx]) begin
                grant_vld = 1'b1;
                grant     = TW'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (fire) begin
            rr_d = (grant == TW'(NREQ-1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`endif

    assign mul_val_op = may_issue && grant_vld && !reset;
    assign fire       = mul_val_op && mul_oprand_rdy;
    assign req_rdy    = fire ? (NREQ'(1) << grant) : '0;
    assign mul_a      = mul_val_op ? req_a[int'(grant)*W +: W] : mul_a_q;
    assign mul_b      = mul_val_op ? req_b[int'(grant)*W +: W] : mul_b_q;

    assign commit_ok   = mul_commit && (infl_q != '0);
    assign rsp_empty   = (rsp_cnt_q == '0);
    assign head_tag    = rsp_tag_mem[rsp_rd_q];
    assign resp_val    = rsp_empty ? '0 : (NREQ'(1) << head_tag);
    assign resp_result = rsp_empty ? '0 : rsp_dat_mem[rsp_rd_q];
    assign rsp_pop     = !rsp_empty && resp_rdy[head_tag];

    always_comb begin
        infl_d = infl_q;
        case ({fire, commit_ok})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase
        rsp_cnt_d = rsp_cnt_q;
        case ({commit_ok, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
            2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            infl_q       <= '0;
            rsp_cnt_q    <= '0;
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            rsp_wr_q     <= '0;
            rsp_rd_q     <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            infl_q    <= infl_d;
            rsp_cnt_q <= rsp_cnt_d;
            if (fire)      tag_wr_q <= tag_wr_q + 1'b1;
            if (commit_ok) tag_rd_q <= tag_rd_q + 1'b1;
            if (commit_ok) rsp_wr_q <= rsp_wr_q + 1'b1;
            if (rsp_pop)   rsp_rd_q <= rsp_rd_q + 1'b1;
            if (mul_val_op) begin
                mul_a_q <= mul_a;
                mul_b_q <= mul_b;
            end
            if (mul_commit && (infl_q == '0)) err_orphan_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) tag_mem[tag_wr_q] <= grant;
        if (commit_ok) begin
            rsp_tag_mem[rsp_wr_q] <= tag_mem[tag_rd_q];
            rsp_dat_mem[rsp_wr_q] <= mul_result;
        end
    end
endmodule

// File: tb/tb_pipe_int_mul_arbiter.sv
// Scoreboarded bench for pipe_int_mul_arbiter with a 3-stage multiplier model.
module tb_pipe_int_mul_arbiter;
    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_val, req_rdy, resp_val, resp_rdy;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [W-1:0]      resp_result, mul_a, mul_b, mul_result;
    logic              mul_val_op, mul_oprand_rdy, mul_commit;

    pipe_int_mul_arbiter #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result),
        .mul_val_op(mul_val_op), .mul_oprand_rdy(mul_oprand_rdy),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_commit(mul_commit), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Fixed-latency multiplier: commit is high three cycles after the issue cycle.
    logic [2:0]   pv;
    logic [W-1:0] pd [3];
    always @(posedge clk or posedge reset) begin
        if (reset) pv <= '0;
        else begin
            pv    <= {pv[1:0], mul_val_op & mul_oprand_rdy};
            pd[0] <= mul_a * mul_b;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign mul_commit = pv[2];
    assign mul_result = pd[2];

    typedef struct { int tag; logic [W-1:0] res; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int n_cmp = 0;
    int n_bad = 0;

`ifdef PIPE_INT_MUL_ARB_FIXED_PRIO_EN
    int t2 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int t3 [6] = '{1, 1, 1, 1, 1, 1};
`else
    int t2 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int t3 [6] = '{1, 3, 1, 3, 1, 3};
`endif
    logic [W-1:0] a2 [4] = '{32'd3, 32'hFFFF_FFFF, 32'd7, 32'h0001_0000};
    logic [W-1:0] b2 [4] = '{32'd5, 32'd2,         32'd6, 32'h0001_0000};
    logic [W-1:0] r2 [4] = '{32'd15, 32'hFFFF_FFFE, 32'd42, 32'd0};
    logic [W-1:0] a3 [4] = '{32'd0, 32'd9, 32'd0, 32'd100};
    logic [W-1:0] b3 [4] = '{32'd0, 32'd9, 32'd0, 32'd1000};
    logic [W-1:0] r3 [4] = '{32'd0, 32'd81, 32'd0, 32'd100000};
    logic [W-1:0] a5 [4] = '{32'd11, 32'h1234_5678, 32'd255, 32'd0};
    logic [W-1:0] b5 [4] = '{32'd13, 32'd16,        32'd255, 32'd0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] a [4], input logic [W-1:0] b [4]);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a[i];
            req_b[i*W +: W] = b[i];
        end
    endtask

    task automatic push_exp(input int tag, input logic [W-1:0] res);
        exp_t x;
        x.tag = tag;
        x.res = res;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string nm);
        resp_rdy = '1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check({"drain_", nm}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check({"idle_", nm}, 64'(resp_val), 64'd0);
        step();
    endtask

    // Monitor: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && resp_val != '0) begin
            check("resp_onehot", 64'($onehot(resp_val)), 64'd1);
            if ((resp_val & resp_rdy) != '0) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_val), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_tag", 64'(resp_val), 64'(1) << e.tag);
                    check("resp_result", 64'(resp_result), 64'(e.res));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        req_val        = '1;
        resp_rdy       = '0;
        mul_oprand_rdy = 1'b1;
        set_ops(a2, b2);

        // Reset state with every requester asserting
        repeat (2) @(negedge clk);
        check("rst_req_rdy",     64'(req_rdy),     64'd0);
        check("rst_resp_val",    64'(resp_val),    64'd0);
        check("rst_mul_val_op",  64'(mul_val_op),  64'd0);
        check("rst_mul_a",       64'(mul_a),       64'd0);
        check("rst_mul_b",       64'(mul_b),       64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        step();
        reset    = 1'b0;
        resp_rdy = '1;

        // Continuous issue from all requesters
        for (int k = 0; k < 8; k++) push_exp(t2[k], r2[t2[k]]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_req_rdy", 64'(req_rdy), 64'(1) << t2[k]);
            check("t2_mul_a",   64'(mul_a),   64'(a2[t2[k]]));
            step();
        end
        req_val = '0;
        @(negedge clk);
        check("hold_val_op", 64'(mul_val_op), 64'd0);
        check("hold_mul_a",  64'(mul_a), 64'(a2[t2[7]]));
        check("hold_mul_b",  64'(mul_b), 64'(b2[t2[7]]));
        step();
        drain("t2");

        // Requesters 1 and 3, with one multiplier stall cycle first
        set_ops(a3, b3);
        mul_oprand_rdy = 1'b0;
        req_val        = 4'b1010;
        @(negedge clk);
        check("stall_val_op",  64'(mul_val_op), 64'd1);
        check("stall_req_rdy", 64'(req_rdy),    64'd0);
        check("stall_mul_a",   64'(mul_a),      64'(a3[t3[0]]));
        step();
        mul_oprand_rdy = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(t3[k], r3[t3[k]]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_req_rdy", 64'(req_rdy), 64'(1) << t3[k]);
            step();
        end
        req_val = '0;
        drain("t3");

        // Credit limit: no response pops, exactly DEPTH accepted
        set_ops(a2, b2);
        resp_rdy = '0;
        req_val  = '1;
        for (int k = 0; k < 8; k++) push_exp(t2[k], r2[t2[k]]);
        push_exp(0, r2[0]);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("cred_req_rdy", 64'(req_rdy), (k < 8) ? (64'(1) << t2[k]) : 64'd0);
            step();
        end
        resp_rdy = 4'b0001;
        @(negedge clk);
        check("cred_pop_req_rdy",  64'(req_rdy),  64'd0);
        check("cred_pop_resp_val", 64'(resp_val), 64'd1);
        step();
        resp_rdy = '0;
        @(negedge clk);
        check("cred_extra_grant", 64'(req_rdy), 64'd1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cred_refull", 64'(req_rdy), 64'd0);
            step();
        end
        req_val = '0;
        drain("cred");

        // Commit, issue and response pop all in one cycle
        set_ops(a5, b5);
        resp_rdy = '0;
        push_exp(0, 32'd143);
        push_exp(1, 32'h2345_6780);
        push_exp(2, 32'd65025);
        req_val = 4'b0001;
        @(negedge clk);
        check("s5_issue_a", 64'(req_rdy), 64'd1);
        step();
        req_val = '0;
        repeat (5) step();
        req_val = 4'b0010;
        @(negedge clk);
        check("s5_issue_b", 64'(req_rdy), 64'd2);
        step();
        req_val = '0;
        step();
        step();
        req_val  = 4'b0100;
        resp_rdy = 4'b0001;
        @(negedge clk);
        check("s5_issue_c",    64'(req_rdy),       64'd4);
        check("s5_head_a",     64'(resp_val),      64'd1);
        check("s5_infl_pre",   64'(dut.infl_q),    64'd1);
        check("s5_rspcnt_pre", 64'(dut.rsp_cnt_q), 64'd1);
        step();
        req_val  = '0;
        resp_rdy = '0;
        @(negedge clk);
        check("s5_infl_post",   64'(dut.infl_q),    64'd1);
        check("s5_rspcnt_post", 64'(dut.rsp_cnt_q), 64'd1);
        check("s5_head_b",      64'(resp_val),      64'd2);
        step();
        drain("s5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
